// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - CLINT register offsets, FSM encoding and byte-mask helper
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  function automatic logic [63:0] apply_mask(input logic [63:0] old,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  mask);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_tick.sv
// rtl/clint_tick.sv - mtime prescaler, one tick every TICK_DIV cycles
module clint_tick #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/clint.sv
// rtl/clint.sv - core-local interruptor: msip, mtimecmp, mtime behind a req/resp port
module clint
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 1,
  parameter bit          BASE_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        time_irq,
  output logic        soft_irq
);

  state_t      state, state_nxt;
  logic        hs, wr_en;
  logic        hit_msip, hit_cmp, hit_time, unmapped;
  logic        tick;
  logic        msip;
  logic [63:0] mtime, mtimecmp;
  logic [63:0] mtime_base, mtime_nxt, rd_val;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign hs         = req_valid & req_ready;
  assign wr_en      = hs & req_wen;

  assign hit_msip = (req_addr == CLINT_MSIP);
  assign hit_cmp  = (req_addr == CLINT_MTIMECMP);
  assign hit_time = (req_addr == CLINT_MTIME);
  assign unmapped = ~(hit_msip | hit_cmp | hit_time);

  clint_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // A same-cycle MTIME write overlays the incremented value, so unwritten bytes still advance.
  assign mtime_base = tick ? (mtime + 64'd1) : mtime;
  assign mtime_nxt  = (wr_en & hit_time) ? apply_mask(mtime_base, req_wdata, req_wmask)
                                         : mtime_base;

  always_comb begin
    rd_val = '0;
    if (hit_msip)      rd_val = {63'd0, msip};
    else if (hit_cmp)  rd_val = mtimecmp;
    else if (hit_time) rd_val = mtime;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      time_irq   <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      mtime    <= mtime_nxt;
      time_irq <= (mtime >= mtimecmp);
      if (wr_en & hit_cmp) mtimecmp <= apply_mask(mtimecmp, req_wdata, req_wmask);
      if (wr_en & hit_msip & req_wmask[0]) msip <= req_wdata[0];
      if (hs) begin
        resp_rdata <= req_wen ? 64'd0 : rd_val;
        resp_err   <= BASE_CHECK ? unmapped : 1'b0;
      end
    end
  end

  assign soft_irq = msip;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (hs) state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_clint.sv
// tb/tb_clint.sv - directed bench for clint with TICK_DIV=1 and TICK_DIV=4 instances
module tb_clint;
  import clint_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wen    [2];
  logic [15:0] req_addr   [2];
  logic [63:0] req_wdata  [2];
  logic [7:0]  req_wmask  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [63:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        time_irq   [2];
  logic        soft_irq   [2];

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  // Edges since reset release; mtime is cyc for the TICK_DIV=1 instance, cyc/4 for the other.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  clint #(.TICK_DIV(1), .BASE_CHECK(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .time_irq(time_irq[0]), .soft_irq(soft_irq[0])
  );

  clint #(.TICK_DIV(4), .BASE_CHECK(1'b1)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .time_irq(time_irq[1]), .soft_irq(soft_irq[1])
  );

  typedef struct {
    logic        wen;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
    logic        exp_soft;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic access(input int d, input logic wen, input logic [15:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask,
                        output logic [63:0] rdata, output logic err,
                        output logic irq_snap, output int hcyc);
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_wen[d]    = wen;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_wmask[d]  = wmask;
    resp_ready[d] = 1'b1;
    chk("req_ready_idle", 64'(req_ready[d]), 64'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    hcyc     = cyc;
    chk("resp_latency", 64'(resp_valid[d]), 64'd1);
    rdata    = resp_rdata[d];
    err      = resp_err[d];
    irq_snap = time_irq[d];
    @(posedge clk);
    #1;
    chk("resp_done", 64'(resp_valid[d]), 64'd0);
  endtask

  task automatic chk_reset(input int d);
    chk("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
    chk("rst_req_ready",  64'(req_ready[d]),  64'd1);
    chk("rst_resp_rdata", resp_rdata[d],      64'd0);
    chk("rst_resp_err",   64'(resp_err[d]),   64'd0);
    chk("rst_time_irq",   64'(time_irq[d]),   64'd0);
    chk("rst_soft_irq",   64'(soft_irq[d]),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        er, irq;
    int          hc;

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_wmask[d] = '0; resp_ready[d] = 1'b1;
    end

    vecs[0]  = '{1'b0, CLINT_MSIP,     64'h0,                  8'h00, 64'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, CLINT_MSIP,     64'h1,                  8'hFF, 64'h0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, CLINT_MSIP,     64'h0,                  8'h00, 64'h1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, CLINT_MSIP,     64'hFFFF_FFFF_FFFF_FFFF, 8'hFE, 64'h0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, CLINT_MSIP,     64'h0,                  8'h00, 64'h1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, CLINT_MSIP,     64'hFFFF_FFFF_FFFF_FFFE, 8'h01, 64'h0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, CLINT_MSIP,     64'h0,                  8'h00, 64'h0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, CLINT_MTIMECMP, 64'h0,                  8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, CLINT_MTIMECMP, 64'h1122_3344_5566_7788, 8'h0F, 64'h0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, CLINT_MTIMECMP, 64'h0,                  8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0, 1'b0};
    vecs[10] = '{1'b1, CLINT_MTIMECMP, 64'h0,                  8'hA0, 64'h0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, CLINT_MTIMECMP, 64'h0,                  8'h00, 64'h00FF_00FF_5566_7788, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 16'h1000,       64'h0,                  8'h00, 64'h0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 16'h0008,       64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 16'h4008,       64'h0,                  8'h00, 64'h0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, CLINT_MTIMECMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, CLINT_MTIMECMP, 64'h0,                  8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[17] = '{1'b0, CLINT_MSIP,     64'h0,                  8'h00, 64'h0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clk);
    rst = 1'b1;

    // Free-running count with no accesses.
    repeat (10) @(posedge clk);
    #1;
    chk("idle_time_irq", 64'(time_irq[0]), 64'd0);
    access(0, 1'b0, CLINT_MTIME, 64'h0, 8'h00, rd, er, irq, hc);
    chk("mtime_after_10", rd, 64'd10);
    access(1, 1'b0, CLINT_MTIME, 64'h0, 8'h00, rd, er, irq, hc);
    chk("mtime_div4", rd, 64'((hc - 1) / 4));

    for (int i = 0; i < 18; i++) begin
      access(0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rd, er, irq, hc);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_soft", i), 64'(soft_irq[0]), 64'(vecs[i].exp_soft));
    end

    // Fresh reset so mtime tracks cyc again for the compare sequence.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset(0);
    @(negedge clk);
    rst = 1'b1;
    access(0, 1'b1, CLINT_MTIMECMP, 64'd20, 8'hFF, rd, er, irq, hc);
    while (cyc < 25) begin
      @(posedge clk);
      #1;
      chk($sformatf("time_irq_cyc%0d", cyc), 64'(time_irq[0]), 64'(cyc >= 21));
    end
    access(0, 1'b1, CLINT_MTIMECMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, irq, hc);
    chk("time_irq_hold", 64'(irq), 64'd1);
    chk("time_irq_fall", 64'(time_irq[0]), 64'd0);

    // 64-bit wrap of mtime.
    access(0, 1'b1, CLINT_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er, irq, hc);
    access(0, 1'b0, CLINT_MTIME, 64'h0, 8'h00, rd, er, irq, hc);
    chk("wrap_allones", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    access(0, 1'b0, CLINT_MTIME, 64'h0, 8'h00, rd, er, irq, hc);
    chk("wrap_past_zero", rd, 64'd1);
    access(0, 1'b1, CLINT_MTIME, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, irq, hc);
    access(0, 1'b0, CLINT_MTIME, 64'h0, 8'h00, rd, er, irq, hc);
    chk("wrap_zero", rd, 64'd0);

    // Stalled response to an unmapped read; a write offered meanwhile must be refused.
    @(negedge clk);
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 16'h1000; resp_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    req_wen[0] = 1'b1; req_addr[0] = CLINT_MSIP; req_wdata[0] = 64'h1; req_wmask[0] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d_valid", i), 64'(resp_valid[0]), 64'd1);
      chk($sformatf("stall%0d_rdata", i), resp_rdata[0], 64'd0);
      chk($sformatf("stall%0d_err", i), 64'(resp_err[0]), 64'd1);
      chk($sformatf("stall%0d_ready", i), 64'(req_ready[0]), 64'd0);
      if (i < 2) begin
        @(posedge clk);
        #1;
      end
    end
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release", 64'(resp_valid[0]), 64'd0);
    chk("stall_no_accept", 64'(soft_irq[0]), 64'd0);

    // Partial MTIME write landing on a tick edge of the divide-by-4 instance.
    while (cyc % 4 != 0) begin
      @(posedge clk);
      #1;
    end
    access(1, 1'b1, CLINT_MTIME, 64'h1FF, 8'hFF, rd, er, irq, hc);
    @(posedge clk);
    #1;
    access(1, 1'b1, CLINT_MTIME, 64'hAA, 8'h01, rd, er, irq, hc);
    chk("tick_edge_write", 64'(hc % 4), 64'd0);
    access(1, 1'b0, CLINT_MTIME, 64'h0, 8'h00, rd, er, irq, hc);
    chk("merge_write_tick", rd, 64'h2AA);

    // Reset while a response is pending.
    @(negedge clk);
    req_valid[1] = 1'b1; req_wen[1] = 1'b0; req_addr[1] = CLINT_MTIMECMP; resp_ready[1] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    chk("pending_resp", 64'(resp_valid[1]), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_drop_resp", 64'(resp_valid[1]), 64'd0);
    chk("rst_mid_ready", 64'(req_ready[1]), 64'd1);
    chk("rst_mid_rdata", resp_rdata[1], 64'd0);
    resp_ready[1] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(req_ready[1]), 64'd1);
    access(1, 1'b0, CLINT_MTIME, 64'h0, 8'h00, rd, er, irq, hc);
    chk("post_rst_mtime", rd, 64'((hc - 1) / 4));
    access(1, 1'b0, CLINT_MTIMECMP, 64'h0, 8'h00, rd, er, irq, hc);
    chk("post_rst_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
